// File: rtl/run_control.sv
// CPU run controller: button sync/debounce, press pulses, reset sequencing, run/halt/step.
// Optional breakpoint halt is compiled in when RUNCTL_BREAK_EN is defined.
module run_control #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 16777215,
  parameter int RESET_HOLD      = 16,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int RST_IDX         = 0,
  parameter int MODE_IDX        = 1,
  parameter int STEP_IDX        = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
`ifdef RUNCTL_BREAK_EN
  input  logic [31:0]        pc,
  input  logic [31:0]        break_addr,
  input  logic               break_valid,
`endif
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] btn_press,
  output logic               cpu_reset_n,
  output logic               cpu_ce,
  output logic               step_mode,
  output logic               halted
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [NUM_BTN-1:0] RELEASED =
    (BTN_ACTIVE_LOW != 0) ? {NUM_BTN{1'b1}} : {NUM_BTN{1'b0}};

  // Two-flop synchroniser on the raw pins, reset to the released pin level
  logic [NUM_BTN-1:0] sync1_reg, sync2_reg, sync_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= RELEASED;
      sync2_reg <= RELEASED;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  assign sync_b = (BTN_ACTIVE_LOW != 0) ? ~sync2_reg : sync2_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_chan
      logic [CNT_W-1:0] db_cnt_reg, db_cnt_next;
      logic             db_level_reg, db_level_next;
      logic             db_press_reg, db_press_next;

      // Any cycle that agrees with the current level restarts the stability count
      always_comb begin
        db_cnt_next   = db_cnt_reg;
        db_level_next = db_level_reg;
        db_press_next = 1'b0;
        if (sync_b[gi] == db_level_reg) begin
          db_cnt_next = '0;
        end else if (db_cnt_reg == DB_LAST) begin
          db_cnt_next   = '0;
          db_level_next = ~db_level_reg;
          db_press_next = ~db_level_reg;
        end else begin
          db_cnt_next = db_cnt_reg + CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          db_cnt_reg   <= '0;
          db_level_reg <= 1'b0;
          db_press_reg <= 1'b0;
        end else begin
          db_cnt_reg   <= db_cnt_next;
          db_level_reg <= db_level_next;
          db_press_reg <= db_press_next;
        end
      end

      assign btn_state[gi] = db_level_reg;
      assign btn_press[gi] = db_press_reg;
    end
  endgenerate

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_STEP = 2'd3
  } fsm_t;

  fsm_t              fsm_reg, fsm_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              step_mode_reg, step_mode_next;
  logic              cpu_reset_n_reg, cpu_ce_reg, halted_reg;
  logic              rst_press, mode_press, step_press, break_hit;

  assign rst_press  = btn_press[RST_IDX];
  assign mode_press = btn_press[MODE_IDX];
  assign step_press = btn_press[STEP_IDX];

`ifdef RUNCTL_BREAK_EN
  assign break_hit = break_valid && (pc == break_addr);
`else
  assign break_hit = 1'b0;
`endif

  always_comb begin
    fsm_next       = fsm_reg;
    hold_cnt_next  = hold_cnt_reg;
    step_mode_next = step_mode_reg;
    if (rst_press) begin
      fsm_next      = S_HOLD;
      hold_cnt_next = '0;
    end else begin
      case (fsm_reg)
        S_HOLD: begin
          if (mode_press) step_mode_next = ~step_mode_reg;
          if (hold_cnt_reg == HOLD_LAST) begin
            hold_cnt_next = '0;
            fsm_next      = step_mode_next ? S_HALT : S_RUN;
          end else begin
            hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
          end
        end
        S_RUN: begin
          // A breakpoint hit takes precedence over a same-cycle mode press
          if (break_hit || mode_press) begin
            step_mode_next = 1'b1;
            fsm_next       = S_HALT;
          end
        end
        S_HALT: begin
          if (mode_press) begin
            step_mode_next = 1'b0;
            fsm_next       = S_RUN;
          end else if (step_press) begin
            fsm_next = S_STEP;
          end
        end
        S_STEP:  fsm_next = S_HALT;
        default: fsm_next = S_HOLD;
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_reg         <= S_HOLD;
      hold_cnt_reg    <= '0;
      step_mode_reg   <= 1'b0;
      cpu_reset_n_reg <= 1'b0;
      cpu_ce_reg      <= 1'b1;
      halted_reg      <= 1'b0;
    end else begin
      fsm_reg         <= fsm_next;
      hold_cnt_reg    <= hold_cnt_next;
      step_mode_reg   <= step_mode_next;
      cpu_reset_n_reg <= (fsm_next != S_HOLD);
      cpu_ce_reg      <= (fsm_next != S_HALT);
      halted_reg      <= (fsm_next == S_HALT);
    end
  end

  assign cpu_reset_n = cpu_reset_n_reg;
  assign cpu_ce      = cpu_ce_reg;
  assign step_mode   = step_mode_reg;
  assign halted      = halted_reg;

endmodule

// File: tb/tb_run_control.sv
// Directed bench for run_control with a scoreboard queue of expected output bundles.
// Bundle layout: {cpu_reset_n, cpu_ce, step_mode, halted, btn_state[3:0], btn_press[3:0]}.
module tb_run_control;

  logic       clk;
  logic       reset;
  logic [3:0] btn_raw;
  logic [3:0] btn_state;
  logic [3:0] btn_press;
  logic       cpu_reset_n;
  logic       cpu_ce;
  logic       step_mode;
  logic       halted;
`ifdef RUNCTL_BREAK_EN
  logic [31:0] pc;
  logic [31:0] break_addr;
  logic        break_valid;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] exp_q[$];
  string       tag_q[$];

  run_control #(
    .NUM_BTN        (4),
    .DEBOUNCE_CYCLES(4),
    .RESET_HOLD     (3),
    .BTN_ACTIVE_LOW (1),
    .RST_IDX        (0),
    .MODE_IDX       (1),
    .STEP_IDX       (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
`ifdef RUNCTL_BREAK_EN
    .pc         (pc),
    .break_addr (break_addr),
    .break_valid(break_valid),
`endif
    .btn_state  (btn_state),
    .btn_press  (btn_press),
    .cpu_reset_n(cpu_reset_n),
    .cpu_ce     (cpu_ce),
    .step_mode  (step_mode),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  function automatic logic [11:0] w(input logic rn, input logic ce, input logic sm,
                                    input logic h, input logic [3:0] bs, input logic [3:0] bp);
    return {rn, ce, sm, h, bs, bp};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check();
    logic [11:0] obs;
    logic [11:0] exp_v;
    string       tag;
    obs = {cpu_reset_n, cpu_ce, step_mode, halted, btn_state, btn_press};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed %h expected <queued entry>", obs);
    end else begin
      exp_v = exp_q.pop_front();
      tag   = tag_q.pop_front();
      assert (obs === exp_v) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
    end
  endtask

  // Queue the expected bundle for the next edge, advance, then compare
  task automatic step_check(input string tag, input logic [11:0] exp_v);
    exp_q.push_back(exp_v);
    tag_q.push_back(tag);
    tick();
    pop_check();
  endtask

  // Hold the masked buttons down until the debounced press pulse is visible, then release
  task automatic press(input logic [3:0] mask);
    btn_raw = btn_raw & ~mask;
    repeat (6) tick();
    btn_raw = btn_raw | mask;
  endtask

  task automatic settle();
    repeat (6) tick();
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 4'hF;
`ifdef RUNCTL_BREAK_EN
    pc          = 32'h0;
    break_addr  = 32'h0;
    break_valid = 1'b0;
`endif
    tick();
    step_check("reset_state", w(0, 1, 0, 0, 4'b0000, 4'b0000));
    reset = 1'b0;

    // Reset hold of three cycles after release
    step_check("hold_a", w(0, 1, 0, 0, 4'b0000, 4'b0000));
    step_check("hold_b", w(0, 1, 0, 0, 4'b0000, 4'b0000));
    step_check("hold_run", w(1, 1, 0, 0, 4'b0000, 4'b0000));

    // Bouncing RST pin never passes the debouncer
    for (int k = 0; k < 6; k++) begin
      btn_raw[0] = k[0];
      for (int j = 0; j < 2; j++) step_check("bounce", w(1, 1, 0, 0, 4'b0000, 4'b0000));
    end
    btn_raw[0] = 1'b0;
    for (int j = 0; j < 5; j++) step_check("db_wait", w(1, 1, 0, 0, 4'b0000, 4'b0000));
    step_check("db_rise", w(1, 1, 0, 0, 4'b0001, 4'b0001));
    btn_raw[0] = 1'b1;
    step_check("rst_hold0", w(0, 1, 0, 0, 4'b0001, 4'b0000));
    step_check("rst_hold1", w(0, 1, 0, 0, 4'b0001, 4'b0000));
    step_check("rst_hold2", w(0, 1, 0, 0, 4'b0001, 4'b0000));
    step_check("rst_run", w(1, 1, 0, 0, 4'b0001, 4'b0000));
    tick();
    step_check("db_fall", w(1, 1, 0, 0, 4'b0000, 4'b0000));

    // Run -> halt, two single steps, back to run, step ignored in run
    press(4'b0010);
    step_check("mode_halt", w(1, 0, 1, 1, 4'b0010, 4'b0000));
    settle();
    for (int s = 0; s < 2; s++) begin
      press(4'b0100);
      step_check("step_on", w(1, 1, 1, 0, 4'b0100, 4'b0000));
      step_check("step_off", w(1, 0, 1, 1, 4'b0100, 4'b0000));
      settle();
    end
    press(4'b0010);
    step_check("mode_run", w(1, 1, 0, 0, 4'b0010, 4'b0000));
    settle();
    press(4'b0100);
    step_check("step_in_run_a", w(1, 1, 0, 0, 4'b0100, 4'b0000));
    step_check("step_in_run_b", w(1, 1, 0, 0, 4'b0100, 4'b0000));
    settle();

    // RST and MODE together: reset wins, step_mode untouched
    press(4'b0011);
    step_check("rm_hold0", w(0, 1, 0, 0, 4'b0011, 4'b0000));
    step_check("rm_hold1", w(0, 1, 0, 0, 4'b0011, 4'b0000));
    step_check("rm_hold2", w(0, 1, 0, 0, 4'b0011, 4'b0000));
    step_check("rm_run", w(1, 1, 0, 0, 4'b0011, 4'b0000));
    settle();

    // Block reset while in STEP, with an unused button held down
    btn_raw[3] = 1'b0;
    repeat (6) tick();
    press(4'b0010);
    step_check("t5_halt", w(1, 0, 1, 1, 4'b1010, 4'b0000));
    settle();
    press(4'b0100);
    step_check("t5_step", w(1, 1, 1, 0, 4'b1100, 4'b0000));
    reset      = 1'b1;
    btn_raw[3] = 1'b1;
    step_check("t5_reset", w(0, 1, 0, 0, 4'b0000, 4'b0000));
    reset = 1'b0;
    step_check("t5_hold0", w(0, 1, 0, 0, 4'b0000, 4'b0000));
    step_check("t5_hold1", w(0, 1, 0, 0, 4'b0000, 4'b0000));
    step_check("t5_run", w(1, 1, 0, 0, 4'b0000, 4'b0000));

`ifdef RUNCTL_BREAK_EN
    break_addr  = 32'h40;
    break_valid = 1'b1;
    pc          = 32'h38;
    step_check("brk_38", w(1, 1, 0, 0, 4'b0000, 4'b0000));
    pc = 32'h3C;
    step_check("brk_3c", w(1, 1, 0, 0, 4'b0000, 4'b0000));
    pc = 32'h40;
    step_check("brk_hit", w(1, 0, 1, 1, 4'b0000, 4'b0000));
    break_valid = 1'b0;
    pc          = 32'h0;
    step_check("brk_stay", w(1, 0, 1, 1, 4'b0000, 4'b0000));
`endif

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
